// File: rtl/sram_sync_fifo_ctrl.sv
// Circular-buffer FIFO controller for one SDP block RAM: 1-cycle read latency (2 with SRAM_FIFO_OUTREG_EN).
// No backpressure on pop data; push/pop are refused via registered full_o/empty_o and logged as sticky errors.
module sram_sync_fifo_ctrl #(
  parameter int DATA_WIDTH       = 40,
  parameter int ADDR_WIDTH       = 9,
  parameter int ALMOST_FULL_LVL  = 496,
  parameter int ALMOST_EMPTY_LVL = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  pop_valid_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   fill_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clr_err_i,
  output logic                  ram_a_clk_o,
  output logic                  ram_b_clk_o,
  output logic                  ram_a_cs_o,
  output logic                  ram_a_we_o,
  output logic [15:0]           ram_a_addr_o,
  output logic [39:0]           ram_a_wrdata_o,
  output logic [39:0]           ram_a_bitmask_o,
  output logic                  ram_b_cs_o,
  output logic                  ram_b_re_o,
  output logic [15:0]           ram_b_addr_o,
  input  logic [39:0]           ram_b_rddata_i
);

  localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_LVL = ALMOST_FULL_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL = ALMOST_EMPTY_LVL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   fill_nxt;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  rd_vld_q;

  assign ram_a_clk_o = clk_i;
  assign ram_b_clk_o = clk_i;

  // RAM strobes are gated by reset so nothing is written while the FIFO is being cleared.
  assign push_acc = push_i & ~full_o & ~rst_i;
  assign pop_acc  = pop_i & ~empty_o & ~rst_i;
  assign fill_nxt = fill_o + {{ADDR_WIDTH{1'b0}}, push_acc} - {{ADDR_WIDTH{1'b0}}, pop_acc};

  always_comb begin
    ram_a_cs_o      = push_acc;
    ram_a_we_o      = push_acc;
    ram_a_addr_o    = '0;
    ram_a_wrdata_o  = '0;
    ram_a_bitmask_o = '0;
    ram_b_cs_o      = pop_acc;
    ram_b_re_o      = pop_acc;
    ram_b_addr_o    = '0;
    if (push_acc) begin
      ram_a_addr_o[6 +: ADDR_WIDTH]    = wr_ptr;
      ram_a_wrdata_o[DATA_WIDTH-1:0]   = push_data_i;
      ram_a_bitmask_o                  = '1;
    end
    if (pop_acc) begin
      ram_b_addr_o[6 +: ADDR_WIDTH] = rd_ptr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_o         <= '0;
      full_o         <= 1'b0;
      almost_full_o  <= 1'b0;
      empty_o        <= 1'b1;
      almost_empty_o <= 1'b1;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
      rd_vld_q       <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      fill_o         <= fill_nxt;
      full_o         <= (fill_nxt == DEPTH);
      almost_full_o  <= (fill_nxt >= AF_LVL);
      empty_o        <= (fill_nxt == '0);
      almost_empty_o <= (fill_nxt <= AE_LVL);
      // A new error in the same cycle as a clear keeps the flag set.
      overflow_o     <= (push_i & full_o) | (overflow_o & ~clr_err_i);
      underflow_o    <= (pop_i & empty_o) | (underflow_o & ~clr_err_i);
      rd_vld_q       <= pop_acc;
    end
  end

`ifdef SRAM_FIFO_OUTREG_EN
  logic                  out_vld_q;
  logic [DATA_WIDTH-1:0] out_dat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      out_vld_q <= rd_vld_q;
      if (rd_vld_q) out_dat_q <= ram_b_rddata_i[DATA_WIDTH-1:0];
    end
  end

  assign pop_valid_o = out_vld_q;
  assign pop_data_o  = out_dat_q;
`else
  logic [DATA_WIDTH-1:0] hold_q;

  // RAM data passes straight through on the valid cycle; hold_q keeps it stable afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         hold_q <= '0;
    else if (rd_vld_q) hold_q <= ram_b_rddata_i[DATA_WIDTH-1:0];
  end

  assign pop_valid_o = rd_vld_q;
  assign pop_data_o  = rd_vld_q ? ram_b_rddata_i[DATA_WIDTH-1:0] : hold_q;
`endif

endmodule

// File: tb/tb_sram_sync_fifo_ctrl.sv
// Randomized bench for sram_sync_fifo_ctrl against a queue-based FIFO model and a behavioural RAM.
module tb_sram_sync_fifo_ctrl;
`ifdef SRAM_FIFO_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 512;

  logic        clk = 1'b0, rst = 1'b1, push = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [39:0] pdata = '0;
  logic [39:0] pop_data_o;
  logic        pop_valid_o, full_o, almost_full_o, empty_o, almost_empty_o;
  logic [9:0]  fill_o;
  logic        overflow_o, underflow_o;
  logic        ram_a_clk_o, ram_b_clk_o, ram_a_cs_o, ram_a_we_o, ram_b_cs_o, ram_b_re_o;
  logic [15:0] ram_a_addr_o, ram_b_addr_o;
  logic [39:0] ram_a_wrdata_o, ram_a_bitmask_o;
  logic [39:0] rddata = '0;

  always #5 clk = ~clk;

  sram_sync_fifo_ctrl dut (
    .clk_i(clk), .rst_i(rst), .push_i(push), .push_data_i(pdata), .pop_i(pop),
    .pop_data_o(pop_data_o), .pop_valid_o(pop_valid_o), .full_o(full_o),
    .almost_full_o(almost_full_o), .empty_o(empty_o), .almost_empty_o(almost_empty_o),
    .fill_o(fill_o), .overflow_o(overflow_o), .underflow_o(underflow_o), .clr_err_i(clr),
    .ram_a_clk_o(ram_a_clk_o), .ram_b_clk_o(ram_b_clk_o), .ram_a_cs_o(ram_a_cs_o),
    .ram_a_we_o(ram_a_we_o), .ram_a_addr_o(ram_a_addr_o), .ram_a_wrdata_o(ram_a_wrdata_o),
    .ram_a_bitmask_o(ram_a_bitmask_o), .ram_b_cs_o(ram_b_cs_o), .ram_b_re_o(ram_b_re_o),
    .ram_b_addr_o(ram_b_addr_o), .ram_b_rddata_i(rddata)
  );

  // Behavioural 512 x 40 SDP RAM, read latency 1, no output register.
  logic [39:0] mem [0:511];
  always @(posedge clk) begin
    if (ram_a_cs_o && ram_a_we_o) mem[ram_a_addr_o[14:6]] <= ram_a_wrdata_o;
    if (ram_b_cs_o && ram_b_re_o) rddata <= mem[ram_b_addr_o[14:6]];
  end

  int total = 0, bad = 0;

  // Reference model: contents queue, push/pop counts and a latency delay line.
  logic [39:0] q[$];
  int          wr_cnt, rd_cnt;
  bit          m_ovf, m_udf, pv0, pv1, m_pop_vld;
  logic [39:0] pd0, pd1, m_pop_data;
  bit          c_awe, c_bre, e_awe, e_bre;
  logic [15:0] c_aaddr, c_baddr, e_aaddr, e_baddr;
  logic [39:0] c_wdata, c_mask;

  task automatic model_reset();
    q.delete();
    wr_cnt = 0; rd_cnt = 0; m_ovf = 0; m_udf = 0;
    pv0 = 0; pv1 = 0; pd0 = '0; pd1 = '0; m_pop_vld = 0; m_pop_data = '0;
  endtask

  function automatic logic [39:0] rnd40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // Drives one cycle starting at posedge+2, samples strobes at posedge+3, returns at next posedge+2.
  task automatic tick(input bit p, input logic [39:0] d, input bit r, input bit c);
    bit ap, ar;
    logic [39:0] popped;
    push = p; pdata = d; pop = r; clr = c;
    #1;
    c_awe = ram_a_cs_o & ram_a_we_o; c_aaddr = ram_a_addr_o; c_wdata = ram_a_wrdata_o;
    c_mask = ram_a_bitmask_o; c_bre = ram_b_cs_o & ram_b_re_o; c_baddr = ram_b_addr_o;
    ap = p && (q.size() < DEPTH);
    ar = r && (q.size() > 0);
    e_awe = ap; e_aaddr = 16'((wr_cnt % DEPTH) * 64);
    e_bre = ar; e_baddr = 16'((rd_cnt % DEPTH) * 64);
    m_ovf = (p && q.size() == DEPTH) || (m_ovf && !c);
    m_udf = (r && q.size() == 0) || (m_udf && !c);
    popped = '0;
    if (ar) begin popped = q.pop_front(); rd_cnt++; end
    if (ap) begin q.push_back(d); wr_cnt++; end
    pv1 = pv0; pd1 = pd0; pv0 = ar; pd0 = popped;
    m_pop_vld = (LAT == 1) ? pv0 : pv1;
    if (m_pop_vld) m_pop_data = (LAT == 1) ? pd0 : pd1;
    @(posedge clk); #2;
    push = 0; pop = 0; clr = 0;
  endtask

  task automatic test_reset();
    rst = 1; push = 1; pdata = 40'h12_3456_789A;
    @(posedge clk); @(posedge clk); #2;
    total++; if (fill_o !== 10'd0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill_o); end
    total++; if ({empty_o, almost_empty_o, full_o, almost_full_o} !== 4'b1100) begin bad++; $display("FAIL reset_flags got=%b exp=1100", {empty_o, almost_empty_o, full_o, almost_full_o}); end
    total++; if ({pop_valid_o, overflow_o, underflow_o} !== 3'b000) begin bad++; $display("FAIL reset_vld_err got=%b exp=000", {pop_valid_o, overflow_o, underflow_o}); end
    total++; if (pop_data_o !== 40'h0) begin bad++; $display("FAIL reset_pop_data got=%h exp=0", pop_data_o); end
    total++; if ({ram_a_cs_o, ram_a_we_o, ram_b_cs_o, ram_b_re_o} !== 4'b0000) begin bad++; $display("FAIL reset_strobes got=%b exp=0000", {ram_a_cs_o, ram_a_we_o, ram_b_cs_o, ram_b_re_o}); end
    total++; if (ram_a_clk_o !== clk || ram_b_clk_o !== clk) begin bad++; $display("FAIL ram_clk got=%b%b exp=%b", ram_a_clk_o, ram_b_clk_o, clk); end
    push = 0; rst = 0;
    model_reset();
    @(posedge clk); #2;
  endtask

  task automatic test_push3();
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL pre_push_empty got=%b exp=1", empty_o); end
    for (int i = 0; i < 3; i++) begin
      tick(1, 40'(i + 1), 0, 0);
      total++; if (c_awe !== 1'b1 || c_aaddr !== 16'(i * 64)) begin bad++; $display("FAIL push3_addr[%0d] got=%b/%h exp=1/%h", i, c_awe, c_aaddr, 16'(i * 64)); end
      total++; if (c_wdata !== 40'(i + 1) || c_mask !== {40{1'b1}}) begin bad++; $display("FAIL push3_data[%0d] got=%h/%h", i, c_wdata, c_mask); end
      if (i == 0) begin
        total++; if (empty_o !== 1'b0) begin bad++; $display("FAIL push3_empty_drop got=%b exp=0", empty_o); end
      end
    end
    total++; if (fill_o !== 10'd3) begin bad++; $display("FAIL push3_fill got=%0d exp=3", fill_o); end
  endtask

  task automatic test_pop3();
    int nv = 0, first = -1;
    logic [39:0] got [3];
    for (int i = 0; i < 6; i++) begin
      tick(0, '0, i < 3, 0);
      if (pop_valid_o === 1'b1) begin
        if (first < 0) first = i;
        if (nv < 3) got[nv] = pop_data_o;
        nv++;
      end
    end
    total++; if (first !== LAT - 1 || nv !== 3) begin bad++; $display("FAIL pop3_timing got first=%0d n=%0d exp first=%0d n=3", first, nv, LAT - 1); end
    for (int k = 0; k < 3; k++) begin
      total++; if (got[k] !== 40'(k + 1)) begin bad++; $display("FAIL pop3_data[%0d] got=%h exp=%0d", k, got[k], k + 1); end
    end
    total++; if (empty_o !== 1'b1 || almost_empty_o !== 1'b1) begin bad++; $display("FAIL pop3_empty got=%b%b exp=11", empty_o, almost_empty_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, rnd40(), 0, 0);
      total++; if (c_awe !== 1'b1 || c_aaddr !== e_aaddr) begin bad++; $display("FAIL fill_write[%0d] got=%b/%h exp=1/%h", i, c_awe, c_aaddr, e_aaddr); end
      total++; if (almost_full_o !== (i + 1 >= 496) || full_o !== (i + 1 == DEPTH)) begin bad++; $display("FAIL fill_flags[%0d] got af=%b f=%b", i + 1, almost_full_o, full_o); end
    end
    tick(1, rnd40(), 0, 0);
    total++; if (c_awe !== 1'b0 || ram_a_cs_o !== 1'b0) begin bad++; $display("FAIL overflow_strobe got=%b exp=0", c_awe); end
    total++; if (overflow_o !== 1'b1 || fill_o !== 10'd512 || full_o !== 1'b1) begin bad++; $display("FAIL overflow_state got ovf=%b fill=%0d full=%b", overflow_o, fill_o, full_o); end
  endtask

  task automatic test_full_pushpop();
    tick(1, rnd40(), 1, 0);
    total++; if (c_awe !== 1'b0 || c_bre !== 1'b1 || c_baddr !== e_baddr) begin bad++; $display("FAIL fullpp_strobes got we=%b re=%b addr=%h exp 0/1/%h", c_awe, c_bre, c_baddr, e_baddr); end
    total++; if (fill_o !== 10'd511 || overflow_o !== 1'b1 || full_o !== 1'b0) begin bad++; $display("FAIL fullpp_state got fill=%0d ovf=%b full=%b", fill_o, overflow_o, full_o); end
    tick(0, '0, 0, 1);
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL clr_err got=%b exp=0", overflow_o); end
    tick(1, rnd40(), 0, 0);
    tick(1, rnd40(), 0, 1);
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL set_beats_clr got=%b exp=1", overflow_o); end
    tick(0, '0, 1, 1);
    total++; if (overflow_o !== 1'b0 || fill_o !== 10'd511) begin bad++; $display("FAIL clr_after got ovf=%b fill=%0d", overflow_o, fill_o); end
  endtask

  task automatic test_stream();
    int wraps = 0, exp_wraps;
    logic [15:0] prev = 16'hFFFF;
    exp_wraps = ((wr_cnt % DEPTH) + 999) / DEPTH;
    for (int i = 0; i < 1000; i++) begin
      tick(1, rnd40(), 1, 0);
      if (prev == 16'h7FC0 && c_aaddr == 16'h0000) wraps++;
      prev = c_aaddr;
      total++; if (c_awe !== 1'b1 || c_bre !== 1'b1 || c_aaddr !== e_aaddr || c_baddr !== e_baddr) begin bad++; $display("FAIL stream_ram[%0d] got %b%b %h %h exp %h %h", i, c_awe, c_bre, c_aaddr, c_baddr, e_aaddr, e_baddr); end
      total++; if (fill_o !== 10'd511) begin bad++; $display("FAIL stream_fill[%0d] got=%0d exp=511", i, fill_o); end
      total++; if (pop_valid_o !== m_pop_vld || (m_pop_vld && pop_data_o !== m_pop_data)) begin bad++; $display("FAIL stream_pop[%0d] got %b/%h exp %b/%h", i, pop_valid_o, pop_data_o, m_pop_vld, m_pop_data); end
    end
    total++; if (wraps !== exp_wraps) begin bad++; $display("FAIL stream_wrap got=%0d exp=%0d", wraps, exp_wraps); end
  endtask

  task automatic test_random();
    int pp, rp;
    for (int ph = 0; ph < 3; ph++) begin
      pp = (ph == 0) ? 20 : (ph == 1) ? 90 : 50;
      rp = (ph == 0) ? 90 : (ph == 1) ? 20 : 50;
      for (int i = 0; i < 1000; i++) begin
        tick($urandom_range(99) < pp, rnd40(), $urandom_range(99) < rp, $urandom_range(99) < 5);
        total++; if (c_awe !== e_awe || c_bre !== e_bre || (e_awe && c_aaddr !== e_aaddr) || (e_bre && c_baddr !== e_baddr)) begin bad++; $display("FAIL rnd_ram[%0d.%0d] got %b%b %h %h exp %b%b %h %h", ph, i, c_awe, c_bre, c_aaddr, c_baddr, e_awe, e_bre, e_aaddr, e_baddr); end
        total++; if (fill_o !== 10'(q.size())) begin bad++; $display("FAIL rnd_fill[%0d.%0d] got=%0d exp=%0d", ph, i, fill_o, q.size()); end
        total++; if ({full_o, almost_full_o, empty_o, almost_empty_o} !== {q.size() == DEPTH, q.size() >= 496, q.size() == 0, q.size() <= 16}) begin bad++; $display("FAIL rnd_flags[%0d.%0d] got=%b fill=%0d", ph, i, {full_o, almost_full_o, empty_o, almost_empty_o}, q.size()); end
        total++; if (overflow_o !== m_ovf || underflow_o !== m_udf) begin bad++; $display("FAIL rnd_err[%0d.%0d] got=%b%b exp=%b%b", ph, i, overflow_o, underflow_o, m_ovf, m_udf); end
        total++; if (pop_valid_o !== m_pop_vld || pop_data_o !== m_pop_data) begin bad++; $display("FAIL rnd_pop[%0d.%0d] got %b/%h exp %b/%h", ph, i, pop_valid_o, pop_data_o, m_pop_vld, m_pop_data); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [39:0] w;
    while (q.size() > 200) tick(0, '0, 1, 0);
    while (q.size() < 200) tick(1, rnd40(), 0, 0);
    for (int i = 0; i < 4; i++) tick(1, rnd40(), 1, 0);
    total++; if (fill_o !== 10'd200 || pop_valid_o !== 1'b1) begin bad++; $display("FAIL arst_pre got fill=%0d vld=%b exp 200/1", fill_o, pop_valid_o); end
    rst = 1;
    #1;
    total++; if (fill_o !== 10'd0 || {empty_o, almost_empty_o, full_o, almost_full_o} !== 4'b1100) begin bad++; $display("FAIL arst_state got fill=%0d flags=%b", fill_o, {empty_o, almost_empty_o, full_o, almost_full_o}); end
    total++; if ({pop_valid_o, overflow_o, underflow_o} !== 3'b000 || pop_data_o !== 40'h0) begin bad++; $display("FAIL arst_out got %b %h", {pop_valid_o, overflow_o, underflow_o}, pop_data_o); end
    model_reset();
    @(posedge clk); #2;
    rst = 0;
    w = rnd40();
    tick(1, w, 0, 0);
    total++; if (c_awe !== 1'b1 || c_aaddr !== 16'h0000) begin bad++; $display("FAIL arst_next_addr got=%b/%h exp=1/0000", c_awe, c_aaddr); end
    tick(0, '0, 1, 0);
    if (LAT == 2) tick(0, '0, 0, 0);
    total++; if (pop_valid_o !== 1'b1 || pop_data_o !== w) begin bad++; $display("FAIL arst_readback got %b/%h exp 1/%h", pop_valid_o, pop_data_o, w); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_push3();
    test_pop3();
    test_full();
    test_full_pushpop();
    test_stream();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
